bit_serializer_tx: RTL and testbench

//  Parallel-to-serial front end for the bit-stream sequence detectors.

---
 rtl/bit_serializer_tx_if.sv | 22 ++
 rtl/bit_serializer_tx.sv | 110 +++++++++++
 tb/tb_bit_serializer_tx.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/bit_serializer_tx_if.sv
// Word-in / bit-out bundle for the serializer: the producer side holds the master modport.
interface bit_serializer_tx_if #(
    parameter int WIDTH = 8
) ();
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             ser_out;
    logic             ser_valid;
    logic             word_done;
    logic             busy;

    modport master (
        output in_data, in_valid,
        input  in_ready, ser_out, ser_valid, word_done, busy
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, ser_out, ser_valid, word_done, busy
    );
endinterface

// File: rtl/bit_serializer_tx.sv
// Parallel-to-serial shifter: one-word holding register feeding a shift register, BIT_DIV clks per bit.
// First bit appears one clk after the accept edge; in_ready is simply !hold_full, so back-to-back words run gap-free.
module bit_serializer_tx #(
    parameter int WIDTH     = 8,
    parameter int BIT_DIV   = 1,
    parameter int MSB_FIRST = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    bit_serializer_tx_if.slave bus
);
    localparam int BW = $clog2(WIDTH);
    localparam int DW = $clog2(BIT_DIV) + 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(BIT_DIV - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [DW-1:0]    div_cnt_q, div_cnt_d;
    logic             word_done_q, word_done_d;

    logic accept;
    logic div_end;
    logic out_bit;

    assign accept  = bus.in_valid && !hold_full_q;
    assign div_end = (div_cnt_q == DIV_LAST);
    assign out_bit = (MSB_FIRST != 0) ? shift_q[WIDTH-1] : shift_q[0];

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        div_cnt_d   = div_cnt_q;
        word_done_d = 1'b0;

        // accept needs an empty hold, a reload needs a full one: never both on one edge
        if (accept) begin
            hold_d      = bus.in_data;
            hold_full_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (hold_full_q) begin
                    shift_d     = hold_q;
                    hold_full_d = 1'b0;
                    bit_cnt_d   = BIT_LAST;
                    div_cnt_d   = '0;
                    state_d     = SHIFT;
                end
            end
            SHIFT: begin
                if (!div_end) begin
                    div_cnt_d = div_cnt_q + DW'(1);
                end else if (bit_cnt_q != '0) begin
                    shift_d   = (MSB_FIRST != 0) ? {shift_q[WIDTH-2:0], 1'b0}
                                                 : {1'b0, shift_q[WIDTH-1:1]};
                    bit_cnt_d = bit_cnt_q - BW'(1);
                    div_cnt_d = '0;
                end else begin
                    word_done_d = 1'b1;
                    div_cnt_d   = '0;
                    if (hold_full_q) begin
                        shift_d     = hold_q;
                        hold_full_d = 1'b0;
                        bit_cnt_d   = BIT_LAST;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            div_cnt_q   <= '0;
            word_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            div_cnt_q   <= div_cnt_d;
            word_done_q <= word_done_d;
        end
    end

    assign bus.in_ready  = !hold_full_q;
    assign bus.ser_valid = (state_q == SHIFT);
    assign bus.ser_out   = (state_q == SHIFT) && out_bit;
    assign bus.word_done = word_done_q;
    assign bus.busy      = (state_q == SHIFT) || hold_full_q;
endmodule

// File: tb/tb_bit_serializer_tx.sv
// Directed bench: three serializer configurations driven from a vector table plus hand-written multi-cycle sequences.
module tb_bit_serializer_tx;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // dut 0: MSB first, div 1; dut 1: MSB first, div 3; dut 2: LSB first, div 1
    bit_serializer_tx_if #(.WIDTH(8)) if0 ();
    bit_serializer_tx_if #(.WIDTH(8)) if1 ();
    bit_serializer_tx_if #(.WIDTH(8)) if2 ();

    bit_serializer_tx #(.WIDTH(8), .BIT_DIV(1), .MSB_FIRST(1)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    bit_serializer_tx #(.WIDTH(8), .BIT_DIV(3), .MSB_FIRST(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    bit_serializer_tx #(.WIDTH(8), .BIT_DIV(1), .MSB_FIRST(0)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    logic       iv [3];
    logic [7:0] id [3];
    logic       so [3];
    logic       sv [3];
    logic       wd [3];
    logic       rdy[3];
    logic       bz [3];

    assign if0.in_valid = iv[0]; assign if0.in_data = id[0];
    assign if1.in_valid = iv[1]; assign if1.in_data = id[1];
    assign if2.in_valid = iv[2]; assign if2.in_data = id[2];
    assign so[0] = if0.ser_out; assign sv[0] = if0.ser_valid; assign wd[0] = if0.word_done;
    assign so[1] = if1.ser_out; assign sv[1] = if1.ser_valid; assign wd[1] = if1.word_done;
    assign so[2] = if2.ser_out; assign sv[2] = if2.ser_valid; assign wd[2] = if2.word_done;
    assign rdy[0] = if0.in_ready; assign bz[0] = if0.busy;
    assign rdy[1] = if1.in_ready; assign bz[1] = if1.busy;
    assign rdy[2] = if2.in_ready; assign bz[2] = if2.busy;

    typedef struct {
        int         dut;
        int         div;
        logic [7:0] data;
        logic [7:0] exp_bits;   // transmitted order, first bit leftmost
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Presents a word and returns at the negedge following the accept edge.
    task automatic send_word(input int d, input logic [7:0] w);
        int n;
        @(negedge clk);
        iv[d] = 1'b1;
        id[d] = w;
        n = 0;
        while (!rdy[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept_timeout", {31'd0, rdy[d]}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        iv[d] = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        send_word(v.dut, v.data);
        check($sformatf("v%0d_hold_rdy", idx), {31'd0, rdy[v.dut]}, 32'd0);
        check($sformatf("v%0d_pre_valid", idx), {31'd0, sv[v.dut]}, 32'd0);
        for (int b = 0; b < 8; b++) begin
            for (int c = 0; c < v.div; c++) begin
                @(negedge clk);
                check($sformatf("v%0d_b%0d_c%0d_valid", idx, b, c), {31'd0, sv[v.dut]}, 32'd1);
                check($sformatf("v%0d_b%0d_c%0d_bit", idx, b, c), {31'd0, so[v.dut]}, {31'd0, v.exp_bits[7-b]});
                check($sformatf("v%0d_b%0d_c%0d_done", idx, b, c), {31'd0, wd[v.dut]}, 32'd0);
                check($sformatf("v%0d_b%0d_c%0d_busy", idx, b, c), {31'd0, bz[v.dut]}, 32'd1);
            end
        end
        @(negedge clk);
        check($sformatf("v%0d_done_pulse", idx), {31'd0, wd[v.dut]}, 32'd1);
        check($sformatf("v%0d_post_valid", idx), {31'd0, sv[v.dut]}, 32'd0);
        check($sformatf("v%0d_post_out", idx), {31'd0, so[v.dut]}, 32'd0);
        @(negedge clk);
        check($sformatf("v%0d_done_end", idx), {31'd0, wd[v.dut]}, 32'd0);
        check($sformatf("v%0d_idle_busy", idx), {31'd0, bz[v.dut]}, 32'd0);
    endtask

    initial begin
        logic [15:0] exp16;
        logic [23:0] exp24;
        int          wd_cnt;
        int          hs_cnt;
        int          sv_seen;
        logic        prev_hs;

        vecs[0] = '{dut: 0, div: 1, data: 8'hA5, exp_bits: 8'b1010_0101};
        vecs[1] = '{dut: 0, div: 1, data: 8'h80, exp_bits: 8'b1000_0000};
        vecs[2] = '{dut: 0, div: 1, data: 8'hFF, exp_bits: 8'b1111_1111};
        vecs[3] = '{dut: 1, div: 3, data: 8'hC3, exp_bits: 8'b1100_0011};
        vecs[4] = '{dut: 2, div: 1, data: 8'h01, exp_bits: 8'b1000_0000};
        vecs[5] = '{dut: 2, div: 1, data: 8'h96, exp_bits: 8'b0110_1001};
        vecs[6] = '{dut: 1, div: 3, data: 8'h5A, exp_bits: 8'b0101_1010};

        for (int d = 0; d < 3; d++) begin
            iv[d] = 1'b0;
            id[d] = 8'h00;
        end

        #12;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("rst%0d_ready", d), {31'd0, rdy[d]}, 32'd1);
            check($sformatf("rst%0d_valid", d), {31'd0, sv[d]}, 32'd0);
            check($sformatf("rst%0d_out", d), {31'd0, so[d]}, 32'd0);
            check($sformatf("rst%0d_done", d), {31'd0, wd[d]}, 32'd0);
            check($sformatf("rst%0d_busy", d), {31'd0, bz[d]}, 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // back-to-back AA then 55 with in_valid held
        exp16 = 16'b1010_1010_0101_0101;
        wd_cnt = 0;
        @(negedge clk);
        iv[0] = 1'b1;
        id[0] = 8'hAA;
        @(posedge clk);
        @(negedge clk);
        check("b2b_rdy_after_acc1", {31'd0, rdy[0]}, 32'd0);
        id[0] = 8'h55;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (k == 0) check("b2b_rdy_free", {31'd0, rdy[0]}, 32'd1);
            if (k == 1) begin
                iv[0] = 1'b0;
                check("b2b_rdy_after_acc2", {31'd0, rdy[0]}, 32'd0);
            end
            if (k == 8) check("b2b_done_first", {31'd0, wd[0]}, 32'd1);
            if (wd[0]) wd_cnt++;
            check($sformatf("b2b_k%0d_valid", k), {31'd0, sv[0]}, 32'd1);
            check($sformatf("b2b_k%0d_bit", k), {31'd0, so[0]}, {31'd0, exp16[15-k]});
        end
        @(negedge clk);
        check("b2b_done_last", {31'd0, wd[0]}, 32'd1);
        check("b2b_end_valid", {31'd0, sv[0]}, 32'd0);
        check("b2b_done_count", wd_cnt, 32'd1);
        @(negedge clk);

        // reset in the middle of 8'hFF
        send_word(0, 8'hFF);
        for (int k = 0; k < 5; k++) @(negedge clk);
        check("mid_rst_pre_valid", {31'd0, sv[0]}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, sv[0]}, 32'd0);
        check("mid_rst_out", {31'd0, so[0]}, 32'd0);
        check("mid_rst_busy", {31'd0, bz[0]}, 32'd0);
        check("mid_rst_ready", {31'd0, rdy[0]}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        sv_seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (sv[0] || bz[0]) sv_seen++;
        end
        check("mid_rst_no_resume", sv_seen, 32'd0);

        // 3C held on in_valid while the hold register is occupied by 81
        exp24 = {8'hF0, 8'h81, 8'h3C};
        hs_cnt = 0;
        prev_hs = 1'b0;
        @(negedge clk);
        iv[0] = 1'b1;
        id[0] = 8'hF0;
        @(posedge clk);
        @(negedge clk);
        id[0] = 8'h81;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            if (prev_hs) iv[0] = 1'b0;
            if (k == 0) prev_hs = 1'b1;
            else prev_hs = 1'b0;
            if (k == 1) begin
                iv[0] = 1'b1;
                id[0] = 8'h3C;
            end
            if (k == 4) check("hold_full_rdy", {31'd0, rdy[0]}, 32'd0);
            if (k >= 2 && iv[0] && rdy[0]) begin
                hs_cnt++;
                prev_hs = 1'b1;
                check("hold_acc_slot", k, 32'd8);
            end
            check($sformatf("hold_k%0d_valid", k), {31'd0, sv[0]}, 32'd1);
            check($sformatf("hold_k%0d_bit", k), {31'd0, so[0]}, {31'd0, exp24[23-k]});
        end
        iv[0] = 1'b0;
        check("hold_accept_once", hs_cnt, 32'd1);
        @(negedge clk);
        check("hold_end_done", {31'd0, wd[0]}, 32'd1);
        check("hold_end_valid", {31'd0, sv[0]}, 32'd0);
        sv_seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (sv[0]) sv_seen++;
        end
        check("hold_no_repeat", sv_seen, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
